int_res_mem_ctrl: RTL and testbench
===================================

Name: int_res_mem_ctrl

Overview:
- Access controller for the intermediate-results store: 4 banks of 14336 words each, 9-bit words, 57344 words total.
- Compute stages issue one request at a time. Each request carries an IntResAddr_t address and a DataWidth_t width.
- The block decodes the flat address into a bank and a bank address. It splits a DOUBLE_WIDTH (18-bit) access into two consecutive single words and returns read data through a response strobe.
- It sits directly below the inference step sequencer, between the compute datapath and the SRAM banks.

Parameters:
- NUM_BANKS, 4, number of intermediate-results banks (CIM_INT_RES_NUM_BANKS).
- BANK_WORDS, 14336, words per bank (CIM_INT_RES_BANK_SIZE_NUM_WORD).
- W, 9, bits per stored word (N_STO_INT_RES).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=write, 0=read.
- req_width  in  1  DataWidth_t; SINGLE_WIDTH or DOUBLE_WIDTH.
- req_addr  in  16  IntResAddr_t flat address.
- req_wdata  in  18  write data; single uses bits [8:0].
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  18  read data.
- addr_err  out  1  one-cycle pulse on an out-of-range request.
- bank_en  out  4  one-hot bank select.
- bank_we  out  1  bank write enable.
- bank_addr  out  14  IntResBankAddr_t.
- bank_wdata  out  9  bank write word.
- bank_rdata  in  36  read words, bank b at [9b+8:9b]; valid 1 cycle after bank_en.

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0. Async assertion clears every output immediately, including mid-access.
- Handshake: a request is accepted on the clk edge where req_valid & req_ready. req_ready=1 only in IDLE.
  - Request fields are registered at acceptance and need not be held afterwards.
  - An unaccepted req_valid waits; it is never dropped.
- Address decode, applied per word:
  - bank = 0/1/2/3 for addr < 14336 / < 28672 / < 43008 / < 57344.
  - bank_addr = addr - bank*14336.
- Double-width layout: word at addr holds data[17:9]; word at addr+1 holds data[8:0]. addr+1 is re-decoded, so a pair may straddle banks (14335 -> bank1/0).
- Range check at acceptance: the request is invalid if addr >= 57344, or if DOUBLE_WIDTH and addr >= 57343.
  - Invalid request: no bank_en asserted; addr_err=1 in the cycle after acceptance; return to IDLE.
  - Invalid read: additionally rsp_valid=1 with rsp_rdata=0 in the cycle after that.
- State machine (bank outputs registered):
  - IDLE -> ACC1 on a valid accepted request; IDLE -> ERR on an invalid accepted request.
  - ACC1: first word driven on bank_en/bank_we/bank_addr/bank_wdata.
    - Next state ACC2 if double, else RD_WAIT if read, else IDLE.
  - ACC2: second word driven.
    - On a read, capture bank_rdata of the ACC1 word as the high half this cycle.
    - Next state RD_WAIT if read, else IDLE.
  - RD_WAIT: no bank_en.
    - Capture the final word from bank_rdata.
    - rsp_valid=1 on the following cycle with rsp_rdata registered; then IDLE.
  - ERR: pulse addr_err (plus the read response above), then IDLE.
- Latency, with acceptance at edge T:
  - single write: bank access in T+1, req_ready in T+2.
  - double write: bank accesses in T+1 and T+2, req_ready in T+3.
  - single read: rsp_valid in T+3.
  - double read: rsp_valid in T+4.
- Single read: rsp_rdata = sign-extension of the 9-bit word to 18 bits.
- bank_en is one-hot or zero, never multi-hot. bank_we=0 whenever bank_en=0.
- Reset mid-operation: the access is abandoned, with no partial response and no addr_err. A double write interrupted after ACC1 leaves only the high word written; that is acceptable.

Decomposition:
- Shared package additions:
  - INT_RES_TOTAL_WORDS = NUM_BANKS*BANK_WORDS.
  - IntResBankSel_t, a logic [1:0] bank index.
  - MemCtrlState_t enum {IDLE, ACC1, ACC2, RD_WAIT, ERR}.
- Existing package types reused: IntResAddr_t, IntResBankAddr_t, IntResSingle_t, IntResDouble_t, DataWidth_t.
- One combinational sub-module: int_res_addr_decode (flat addr -> bank sel, bank addr, in_range). It is instantiated twice: once for addr, once for addr+1.

Test Plan:
- Single write addr=100, wdata=9'h1A5, then single read addr=100.
  -> bank_en=4'b0001, bank_addr=100 in T+1; read rsp_valid at T+3 with rsp_rdata=18'h3FFA5.
- Double write addr=14335, wdata=18'h2ABCD.
  -> bank0 addr 14335 gets 9'h155, then bank1 addr 0 gets 9'h1CD.
  -> A double read of addr 14335 returns 18'h2ABCD at T+4.
- Single write addr=57344.
  -> bank_en stays 0, addr_err=1 for exactly one cycle, req_ready=1 two cycles after acceptance.
- Double read addr=57343.
  -> addr_err pulse, then rsp_valid with rsp_rdata=0, no bank access.
- req_valid held high during a double write.
  -> The second request is accepted only when req_ready returns at T+3; no request is lost or duplicated.
- Assert rst during ACC2 of a double write.
  -> bank_en=0 and rsp_valid=0 immediately; req_ready=1 after release; the next access completes correctly.

Source files
------------

// File: rtl/int_res_mem_ctrl_pkg.sv
// Shared types and constants for the intermediate-results store controller.
// Holds address/data types, the bank geometry, the controller state encoding
// and small helpers for bank selection and read-word extraction.
package int_res_mem_ctrl_pkg;

    localparam int unsigned NUM_BANKS           = 4;
    localparam int unsigned BANK_WORDS          = 14336;
    localparam int unsigned W                   = 9;
    localparam int unsigned INT_RES_TOTAL_WORDS = NUM_BANKS * BANK_WORDS;

    typedef logic [15:0]      IntResAddr_t;
    typedef logic [13:0]      IntResBankAddr_t;
    typedef logic [W-1:0]     IntResSingle_t;
    typedef logic [2*W-1:0]   IntResDouble_t;
    typedef logic [1:0]       IntResBankSel_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [2:0] {
        IDLE,
        ACC1,
        ACC2,
        RD_WAIT,
        ERR
    } MemCtrlState_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input IntResBankSel_t sel);
        logic [NUM_BANKS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

    // Bank b returns its word on bank_rdata[9b+8:9b].
    function automatic IntResSingle_t bank_word(input logic [NUM_BANKS*W-1:0] rdata,
                                                input IntResBankSel_t        sel);
        return rdata[W*int'(sel) +: W];
    endfunction

endpackage

// File: rtl/int_res_addr_decode.sv
// Flat intermediate-results address -> (bank select, bank-local address).
// Ports:
//   addr      flat word address
//   bank_sel  bank index (0..3), 0 when out of range
//   bank_addr address within the selected bank, 0 when out of range
//   in_range  addr < INT_RES_TOTAL_WORDS
module int_res_addr_decode
    import int_res_mem_ctrl_pkg::*;
(
    input  IntResAddr_t     addr,
    output IntResBankSel_t  bank_sel,
    output IntResBankAddr_t bank_addr,
    output logic            in_range
);

    localparam IntResAddr_t LIM1 = IntResAddr_t'(BANK_WORDS);
    localparam IntResAddr_t LIM2 = IntResAddr_t'(2 * BANK_WORDS);
    localparam IntResAddr_t LIM3 = IntResAddr_t'(3 * BANK_WORDS);
    localparam IntResAddr_t LIM4 = IntResAddr_t'(INT_RES_TOTAL_WORDS);

    IntResAddr_t base;

    always_comb begin
        bank_sel = '0;
        base     = '0;
        in_range = 1'b1;
        if (addr < LIM1) begin
            bank_sel = 2'd0;
            base     = '0;
        end else if (addr < LIM2) begin
            bank_sel = 2'd1;
            base     = LIM1;
        end else if (addr < LIM3) begin
            bank_sel = 2'd2;
            base     = LIM2;
        end else if (addr < LIM4) begin
            bank_sel = 2'd3;
            base     = LIM3;
        end else begin
            in_range = 1'b0;
            base     = addr;
        end
        bank_addr = IntResBankAddr_t'(addr - base);
    end

endmodule

// File: rtl/int_res_mem_ctrl.sv
// Access controller for the intermediate-results store (4 banks x 14336 x 9b).
// Accepts one request at a time, decodes the flat address into bank/bank
// address, splits double-width accesses into two word accesses (high half at
// addr, low half at addr+1) and returns read data via a one-cycle strobe.
// Ports:
//   req_*      request handshake (valid/ready), direction, width, address, data
//   rsp_valid  one-cycle read-data strobe, rsp_rdata the 18-bit read data
//   addr_err   one-cycle pulse for an out-of-range request
//   bank_*     registered SRAM bank interface; bank_rdata valid 1 cycle after bank_en
module int_res_mem_ctrl
    import int_res_mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_width,
    input  logic [15:0] req_addr,
    input  logic [17:0] req_wdata,
    output logic        rsp_valid,
    output logic [17:0] rsp_rdata,
    output logic        addr_err,
    output logic [3:0]  bank_en,
    output logic        bank_we,
    output logic [13:0] bank_addr,
    output logic [8:0]  bank_wdata,
    input  logic [35:0] bank_rdata
);

    MemCtrlState_t   state;
    logic            is_dbl;
    logic            is_wr;
    IntResBankSel_t  sel_hi;
    IntResBankSel_t  sel_lo;
    IntResBankAddr_t addr_lo;
    IntResSingle_t   wdata_lo;
    IntResSingle_t   rdata_hi;

    IntResAddr_t     addr_next;
    IntResBankSel_t  dec0_sel, dec1_sel;
    IntResBankAddr_t dec0_addr, dec1_addr;
    logic            dec0_ok, dec1_ok;
    logic            req_dbl;
    logic            req_ok;
    IntResSingle_t   rword;

    assign addr_next = req_addr + IntResAddr_t'(1);

    int_res_addr_decode u_dec_first (
        .addr      (req_addr),
        .bank_sel  (dec0_sel),
        .bank_addr (dec0_addr),
        .in_range  (dec0_ok)
    );

    int_res_addr_decode u_dec_second (
        .addr      (addr_next),
        .bank_sel  (dec1_sel),
        .bank_addr (dec1_addr),
        .in_range  (dec1_ok)
    );

    assign req_dbl = (req_width == DOUBLE_WIDTH);
    // addr+1 wraps to 0 at 65535, but then the first word is already out of range.
    assign req_ok  = dec0_ok & (~req_dbl | dec1_ok);
    // Final word comes from the second bank on a double read, else the only one.
    assign rword   = bank_word(bank_rdata, is_dbl ? sel_lo : sel_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            addr_err   <= 1'b0;
            bank_en    <= '0;
            bank_we    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            is_dbl     <= 1'b0;
            is_wr      <= 1'b0;
            sel_hi     <= '0;
            sel_lo     <= '0;
            addr_lo    <= '0;
            wdata_lo   <= '0;
            rdata_hi   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            addr_err  <= 1'b0;
            bank_en   <= '0;
            bank_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        is_dbl    <= req_dbl;
                        is_wr     <= req_write;
                        sel_hi    <= dec0_sel;
                        sel_lo    <= dec1_sel;
                        addr_lo   <= dec1_addr;
                        wdata_lo  <= req_wdata[8:0];
                        if (req_ok) begin
                            state      <= ACC1;
                            bank_en    <= bank_onehot(dec0_sel);
                            bank_we    <= req_write;
                            bank_addr  <= dec0_addr;
                            bank_wdata <= req_dbl ? req_wdata[17:9] : req_wdata[8:0];
                        end else begin
                            state    <= ERR;
                            addr_err <= 1'b1;
                        end
                    end
                end
                ACC1: begin
                    if (is_dbl) begin
                        state      <= ACC2;
                        bank_en    <= bank_onehot(sel_lo);
                        bank_we    <= is_wr;
                        bank_addr  <= addr_lo;
                        bank_wdata <= wdata_lo;
                    end else if (!is_wr) begin
                        state <= RD_WAIT;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ACC2: begin
                    if (!is_wr) begin
                        rdata_hi <= bank_word(bank_rdata, sel_hi);
                        state    <= RD_WAIT;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= is_dbl ? {rdata_hi, rword} : {{W{rword[W-1]}}, rword};
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                ERR: begin
                    rsp_valid <= ~is_wr;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_res_mem_ctrl.sv
// Scoreboard bench for int_res_mem_ctrl: a flat-array reference memory predicts
// bank traffic, read responses and address errors; a monitor compares them.
module tb_int_res_mem_ctrl;

    localparam int TOTAL = 57344;
    localparam int BW    = 14336;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_width;
    logic [15:0] req_addr;
    logic [17:0] req_wdata;
    logic        rsp_valid;
    logic [17:0] rsp_rdata;
    logic        addr_err;
    logic [3:0]  bank_en;
    logic        bank_we;
    logic [13:0] bank_addr;
    logic [8:0]  bank_wdata;
    logic [35:0] bank_rdata;

    int_res_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .addr_err   (addr_err),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  en;
        logic        we;
        logic [13:0] addr;
        logic [8:0]  wdata;
        int          t;
    } bank_exp_t;

    typedef struct {
        logic [17:0] data;
        int          t;
    } rsp_exp_t;

    bank_exp_t bq[$];
    rsp_exp_t  rq[$];
    int        eq[$];

    logic [8:0] ref_mem [TOTAL];
    logic [8:0] sram [4][BW];

    function automatic logic [8:0] init_word(input int i);
        return 9'((i * 37 + 11) ^ (i >> 5));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural SRAM banks: 1-cycle read latency.
    initial begin
        bank_rdata = '0;
        for (int i = 0; i < TOTAL; i++) sram[i / BW][i % BW] = init_word(i);
        forever begin
            @(posedge clk);
            for (int b = 0; b < 4; b++) begin
                if (bank_en[b]) begin
                    if (bank_we) sram[b][bank_addr] = bank_wdata;
                    else bank_rdata[b*9 +: 9] <= sram[b][bank_addr];
                end
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bank_en != 4'b0) begin
                check("bank_onehot", 32'($onehot(bank_en)), 32'd1);
                if (bq.size() == 0) begin
                    check("bank_unexpected", {28'd0, bank_en}, 32'd0);
                end else begin
                    bank_exp_t e;
                    e = bq.pop_front();
                    check("bank_en", {28'd0, bank_en}, {28'd0, e.en});
                    check("bank_we", {31'd0, bank_we}, {31'd0, e.we});
                    check("bank_addr", {18'd0, bank_addr}, {18'd0, e.addr});
                    check("bank_time", cyc, e.t);
                    if (e.we) check("bank_wdata", {23'd0, bank_wdata}, {23'd0, e.wdata});
                end
            end else if (bank_we) begin
                check("bank_we_idle", 32'd1, 32'd0);
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    check("rsp_unexpected", {14'd0, rsp_rdata}, 32'd0);
                end else begin
                    rsp_exp_t r;
                    r = rq.pop_front();
                    check("rsp_rdata", {14'd0, rsp_rdata}, {14'd0, r.data});
                    check("rsp_time", cyc, r.t);
                end
            end
            if (addr_err) begin
                if (eq.size() == 0) begin
                    check("err_unexpected", 32'd1, 32'd0);
                end else begin
                    int te;
                    te = eq.pop_front();
                    check("err_time", cyc, te);
                end
            end
        end
    end

    int have_prev = 0;
    int prev_t    = 0;
    int prev_gap  = 0;

    // Present a request, wait (bounded) for acceptance and push expectations.
    // req_valid is left high so consecutive calls are back-to-back.
    task automatic issue(input logic wr, input logic dbl, input int addr, input logic [17:0] wd);
        logic rdy;
        bit   acc;
        int   t;
        bit   ok;
        req_write = wr;
        req_width = dbl;
        req_addr  = 16'(addr);
        req_wdata = wd;
        req_valid = 1'b1;
        acc = 0;
        for (int w = 0; w < 40 && !acc; w++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            have_prev = 0;
            return;
        end
        t = cyc;
        if (have_prev != 0) check("accept_gap", t - prev_t, prev_gap);
        ok = (addr < TOTAL) && (!dbl || addr + 1 < TOTAL);
        if (!ok) begin
            eq.push_back(t);
            if (!wr) rq.push_back('{18'd0, t + 1});
            prev_gap = 2;
        end else begin
            bq.push_back('{4'(1 << (addr / BW)), wr, 14'(addr % BW), dbl ? wd[17:9] : wd[8:0], t});
            if (dbl) bq.push_back('{4'(1 << ((addr + 1) / BW)), wr, 14'((addr + 1) % BW), wd[8:0], t + 1});
            if (wr) begin
                if (dbl) begin
                    ref_mem[addr]     = wd[17:9];
                    ref_mem[addr + 1] = wd[8:0];
                end else begin
                    ref_mem[addr] = wd[8:0];
                end
                prev_gap = dbl ? 3 : 2;
            end else begin
                logic [8:0] hi;
                hi = ref_mem[addr];
                if (dbl) rq.push_back('{{hi, ref_mem[addr + 1]}, t + 3});
                else     rq.push_back('{{{9{hi[8]}}, hi}, t + 2});
                prev_gap = dbl ? 4 : 3;
            end
        end
        prev_t    = t;
        have_prev = 1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        have_prev = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int boundary [11] = '{0, 14335, 14336, 28671, 28672, 43007, 43008, 57342, 57343, 57344, 65535};

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_width = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < TOTAL; i++) ref_mem[i] = init_word(i);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_bank_en", {28'd0, bank_en}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_addr_err", {31'd0, addr_err}, 32'd0);
        check("reset_rsp_rdata", {14'd0, rsp_rdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(1'b1, 1'b0, 100, 18'h001A5);
        issue(1'b0, 1'b0, 100, 18'h0);
        idle(4);
        issue(1'b1, 1'b1, 14335, 18'h2ABCD);
        issue(1'b0, 1'b1, 14335, 18'h0);
        idle(5);
        issue(1'b1, 1'b0, 57344, 18'h00055);
        issue(1'b0, 1'b1, 57343, 18'h0);
        idle(4);
        issue(1'b1, 1'b1, 5000, 18'h3F00F);
        issue(1'b1, 1'b0, 5002, 18'h00123);
        issue(1'b0, 1'b1, 5000, 18'h0);
        issue(1'b0, 1'b1, 5001, 18'h0);
        idle(5);

        // Reset during ACC2 of a double write: only the high word lands.
        begin
            logic [8:0] old_lo;
            old_lo = ref_mem[28672];
            issue(1'b1, 1'b1, 28671, 18'h1E3C7);
            void'(bq.pop_back());
            ref_mem[28672] = old_lo;
            req_valid = 1'b0;
            have_prev = 0;
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("rst_bank_en", {28'd0, bank_en}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_req_ready", {31'd0, req_ready}, 32'd1);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("post_rst_ready", {31'd0, req_ready}, 32'd1);
            issue(1'b0, 1'b1, 28671, 18'h0);
            idle(6);
        end

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int   a;
            logic wr, dbl;
            case ($urandom_range(0, 9))
                0, 1:    a = boundary[$urandom_range(0, 10)];
                2:       a = $urandom_range(57340, 65535);
                default: a = $urandom_range(0, TOTAL - 1);
            endcase
            wr  = 1'($urandom);
            dbl = 1'($urandom);
            issue(wr, dbl, a, 18'($urandom));
            if ($urandom_range(0, 9) < 3) idle($urandom_range(0, 3));
        end
        idle(10);

        check("bank_queue_empty", bq.size(), 0);
        check("rsp_queue_empty", rq.size(), 0);
        check("err_queue_empty", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
